traffic_controller: RTL

TRAFFIC_CONTROLLER -- requirements
Module: traffic_controller

---
 rtl/traffic_controller.sv | 162 ++++++++++++++++
 1 files changed

// File: rtl/traffic_controller.sv
// Main/side intersection controller with pedestrian walk phase.
// Registered lamp vector and phase code; timing derived from a shared tick prescaler.
module traffic_controller #(
    parameter int TICK_DIV = 100,
    parameter int T_MG     = 6,
    parameter int T_Y      = 2,
    parameter int T_AR     = 1,
    parameter int T_SG     = 4,
    parameter int T_WALK   = 3
) (
    input  logic       clk,
    input  logic       reset,
    input  logic       car_sense,
    input  logic       walk_btn,
    output logic [6:0] signal,
    output logic [2:0] phase
);

    localparam int T_MAX_A = (T_MG > T_Y) ? T_MG : T_Y;
    localparam int T_MAX_B = (T_AR > T_SG) ? T_AR : T_SG;
    localparam int T_MAX_C = (T_MAX_A > T_MAX_B) ? T_MAX_A : T_MAX_B;
    localparam int T_MAX   = (T_MAX_C > T_WALK) ? T_MAX_C : T_WALK;
    localparam int TW      = $clog2(T_MAX + 1);
    localparam int PW      = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;

    localparam logic [PW-1:0] PRESC_LAST = PW'(TICK_DIV - 1);
    localparam logic [TW-1:0] MG_SAT     = TW'(T_MG);
    localparam logic [TW-1:0] Y_LAST     = TW'(T_Y - 1);
    localparam logic [TW-1:0] AR_LAST    = TW'(T_AR - 1);
    localparam logic [TW-1:0] SG_LAST    = TW'(T_SG - 1);
    localparam logic [TW-1:0] WALK_LAST  = TW'(T_WALK - 1);

    // Lamp bits: [0] r_m, [1] y_m, [2] g_m, [3] r_s, [4] y_s, [5] g_s, [6] walk
    localparam logic [6:0] L_MG   = 7'b0001100;
    localparam logic [6:0] L_MY   = 7'b0001010;
    localparam logic [6:0] L_AR   = 7'b0001001;
    localparam logic [6:0] L_SG   = 7'b0100001;
    localparam logic [6:0] L_SY   = 7'b0010001;
    localparam logic [6:0] L_WALK = 7'b1001001;

    typedef enum logic [2:0] {
        S_MG   = 3'd0,
        S_MY   = 3'd1,
        S_ARM  = 3'd2,
        S_SG   = 3'd3,
        S_SY   = 3'd4,
        S_ARS  = 3'd5,
        S_WALK = 3'd6
    } state_t;

    state_t        state_q, state_d;
    logic [PW-1:0] presc_q, presc_d;
    logic [TW-1:0] tick_cnt_q, tick_cnt_d;
    logic          side_req_q, side_req_d;
    logic          walk_req_q, walk_req_d;
    logic [6:0]    signal_q, signal_d;
    logic [2:0]    phase_q, phase_d;
    logic          tick;
    logic          changing;

    function automatic logic [6:0] lamp(input state_t s);
        case (s)
            S_MG:    lamp = L_MG;
            S_MY:    lamp = L_MY;
            S_ARM:   lamp = L_AR;
            S_SG:    lamp = L_SG;
            S_SY:    lamp = L_SY;
            S_ARS:   lamp = L_AR;
            S_WALK:  lamp = L_WALK;
            default: lamp = L_MG;
        endcase
    endfunction

    assign tick = (presc_q == PRESC_LAST);

    always_comb begin
        state_d = state_q;
        case (state_q)
            S_MG: begin
                if ((tick_cnt_q == MG_SAT) && (side_req_q || walk_req_q)) begin
                    state_d = S_MY;
                end
            end
            S_MY: begin
                if (tick && (tick_cnt_q == Y_LAST)) state_d = S_ARM;
            end
            S_ARM: begin
                if (tick && (tick_cnt_q == AR_LAST)) begin
                    state_d = side_req_q ? S_SG : S_WALK;
                end
            end
            S_SG: begin
                if (tick && (tick_cnt_q == SG_LAST)) state_d = S_SY;
            end
            S_SY: begin
                if (tick && (tick_cnt_q == Y_LAST)) state_d = S_ARS;
            end
            S_ARS: begin
                if (tick && (tick_cnt_q == AR_LAST)) begin
                    state_d = walk_req_q ? S_WALK : S_MG;
                end
            end
            S_WALK: begin
                if (tick && (tick_cnt_q == WALK_LAST)) state_d = S_MG;
            end
            default: state_d = S_MG;
        endcase
    end

    // Timers restart on every state change so each phase gets its full duration.
    always_comb begin
        changing   = (state_d != state_q);
        presc_d    = presc_q + PW'(1);
        tick_cnt_d = tick_cnt_q;
        if (changing || tick) begin
            presc_d = '0;
        end
        if (changing) begin
            tick_cnt_d = '0;
        end else if (tick && !((state_q == S_MG) && (tick_cnt_q == MG_SAT))) begin
            tick_cnt_d = tick_cnt_q + TW'(1);
        end
    end

    // Entering the serving state clears its request even if the input is still high.
    always_comb begin
        side_req_d = side_req_q | car_sense;
        walk_req_d = walk_req_q | walk_btn;
        if ((state_d == S_SG) && (state_q != S_SG)) begin
            side_req_d = 1'b0;
        end
        if ((state_d == S_WALK) && (state_q != S_WALK)) begin
            walk_req_d = 1'b0;
        end
        signal_d = lamp(state_d);
        phase_d  = state_d;
    end

    always_ff @(posedge clk) begin
        if (!reset) begin
            state_q    <= S_MG;
            presc_q    <= '0;
            tick_cnt_q <= '0;
            side_req_q <= 1'b0;
            walk_req_q <= 1'b0;
            signal_q   <= L_MG;
            phase_q    <= 3'd0;
        end else begin
            state_q    <= state_d;
            presc_q    <= presc_d;
            tick_cnt_q <= tick_cnt_d;
            side_req_q <= side_req_d;
            walk_req_q <= walk_req_d;
            signal_q   <= signal_d;
            phase_q    <= phase_d;
        end
    end

    assign signal = signal_q;
    assign phase  = phase_q;

endmodule
